regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_fifo.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and widths used by the arbiter and its LL result FIFO.
package regfile_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int REG_DATA_W  = 32;
    localparam int COUNT_W     = 4;
    localparam int STARVE_W    = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small circular buffer of long-latency writeback results; pointers wrap modulo DEPTH,
// which need not be a power of two. Storage is not reset, so contents are dropped on reset.
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  wb_entry_t          push_entry,
    input  logic               pop,
    output logic [COUNT_W-1:0] count,
    output wb_entry_t          head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees its slot in the same cycle, so a full buffer can still take a push alongside it.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < DEPTH_C) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered
// long-latency results. Optional busy scoreboard enabled by REGFILE_WB_ARB_SCOREBOARD_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MEM_WB_Freeze,
    input  logic                  Pipe_WE,
    input  logic [REG_ADDR_W-1:0] Pipe_Addr,
    input  logic [REG_DATA_W-1:0] Pipe_Data,
    input  logic                  LL_Issue_Valid,
    input  logic [REG_ADDR_W-1:0] LL_Issue_Addr,
    input  logic                  LL_Valid,
    output logic                  LL_Ready,
    input  logic [REG_ADDR_W-1:0] LL_Addr,
    input  logic [REG_DATA_W-1:0] LL_Data,
    output logic                  Reg_Write_Enable,
    output logic [REG_ADDR_W-1:0] RD_Write_Addr,
    output logic [REG_DATA_W-1:0] RD_Write_Data,
    output logic                  Pipe_Stall,
    output logic [31:0]           Busy_Mask,
    output logic [COUNT_W-1:0]    Fifo_Count
);

    localparam logic [COUNT_W-1:0]  DEPTH_C = COUNT_W'(FIFO_DEPTH);
    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    wb_entry_t           head;
    wb_entry_t           wr_entry;
    logic                wr_valid;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;

    // LL results always go through the buffer; readiness depends on registered occupancy only.
    assign LL_Ready   = (Fifo_Count < DEPTH_C);
    assign push       = LL_Valid && LL_Ready;
    assign fifo_empty = (Fifo_Count == '0);

    regfile_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_entry ('{addr: LL_Addr, data: LL_Data}),
        .pop        (pop),
        .count      (Fifo_Count),
        .head       (head)
    );

    // Pipe has fixed priority even while stalled; the stall only asks the pipeline to back off.
    always_comb begin
        wr_valid    = 1'b0;
        wr_entry    = '0;
        pop         = 1'b0;
        starve_next = starve_cnt;
        if (!MEM_WB_Freeze) begin
            if (Pipe_WE) begin
                wr_valid = 1'b1;
                wr_entry = '{addr: Pipe_Addr, data: Pipe_Data};
                if (!fifo_empty && (starve_cnt != LIMIT_C)) begin
                    starve_next = starve_cnt + 1'b1;
                end
            end else if (!fifo_empty) begin
                wr_valid    = 1'b1;
                wr_entry    = head;
                pop         = 1'b1;
                starve_next = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Reg_Write_Enable <= 1'b0;
            RD_Write_Addr    <= '0;
            RD_Write_Data    <= '0;
            starve_cnt       <= '0;
            Pipe_Stall       <= 1'b0;
        end else begin
            // Writes to r0 still consume their slot but never strobe the register file.
            Reg_Write_Enable <= wr_valid && (wr_entry.addr != '0);
            if (wr_valid) begin
                RD_Write_Addr <= wr_entry.addr;
                RD_Write_Data <= wr_entry.data;
            end
            starve_cnt <= starve_next;
            Pipe_Stall <= (starve_next == LIMIT_C);
        end
    end

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (LL_Issue_Valid && (LL_Issue_Addr != '0)) begin
            busy_set[LL_Issue_Addr] = 1'b1;
        end
        if (pop) begin
            busy_clr[head.addr] = 1'b1;
        end
    end

    // A new issue to a register being retired in the same cycle keeps the bit set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Busy_Mask <= '0;
        end else begin
            Busy_Mask <= ((Busy_Mask & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
        end
    end
`else
    logic unused_issue;

    assign unused_issue = ^{LL_Issue_Valid, LL_Issue_Addr};
    assign Busy_Mask    = '0;
`endif

endmodule
